// File: rtl/apb_master_bridge_if.sv
// APB3 bus between apb_master_bridge and its four peripheral slots.
interface apb_master_bridge_if;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        PENABLE;
  logic        PSEL0;
  logic        PSEL1;
  logic        PSEL2;
  logic        PSEL3;
  logic [31:0] PRDATA0;
  logic [31:0] PRDATA1;
  logic [31:0] PRDATA2;
  logic [31:0] PRDATA3;
  logic        PREADY0;
  logic        PREADY1;
  logic        PREADY2;
  logic        PREADY3;

  modport master (
    output PADDR, PWRITE, PWDATA, PENABLE, PSEL0, PSEL1, PSEL2, PSEL3,
    input  PRDATA0, PRDATA1, PRDATA2, PRDATA3,
    input  PREADY0, PREADY1, PREADY2, PREADY3
  );

  modport slave (
    input  PADDR, PWRITE, PWDATA, PENABLE, PSEL0, PSEL1, PSEL2, PSEL3,
    output PRDATA0, PRDATA1, PRDATA2, PRDATA3,
    output PREADY0, PREADY1, PREADY2, PREADY3
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Core load/store to APB3 bridge with four slots decoded from addr[15:12].
// Optional ACCESS-phase watchdog enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        transfer,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  apb_master_bridge_if.master apb
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e      state_q;
  logic [31:0] paddr_q;
  logic [31:0] pwdata_q;
  logic        pwrite_q;
  logic        penable_q;
  logic [3:0]  psel_q;
  logic [1:0]  slot_q;
  logic        errPend_q;

  logic [3:0]  preadyVec;
  logic [31:0] prdataSel;
  logic        selReady;
  logic        accessDone;
  logic        addrHit;
  logic        timeoutHit;

  assign preadyVec  = {apb.PREADY3, apb.PREADY2, apb.PREADY1, apb.PREADY0};
  assign selReady   = preadyVec[slot_q];
  assign accessDone = (state_q == ACCESS) && selReady;
  assign addrHit    = (addr[31:16] == BASE_ADDR[31:16]) && (addr[15:12] < 4'd4);

  always_comb begin
    prdataSel = '0;
    case (slot_q)
      2'd0: prdataSel = apb.PRDATA0;
      2'd1: prdataSel = apb.PRDATA1;
      2'd2: prdataSel = apb.PRDATA2;
      2'd3: prdataSel = apb.PRDATA3;
      default: prdataSel = '0;
    endcase
  end

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CntLog   = $clog2(TIMEOUT_CYC);
  localparam int unsigned CntWidth = (CntLog < 8) ? 8 : ((CntLog > 16) ? 16 : CntLog);

  logic [CntWidth-1:0] toCnt_q;

  // Counts stalled ACCESS cycles; cleared while passing through SETUP.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      toCnt_q <= '0;
    end else if (state_q == SETUP) begin
      toCnt_q <= '0;
    end else if ((state_q == ACCESS) && !selReady) begin
      toCnt_q <= toCnt_q + 1'b1;
    end
  end

  assign timeoutHit = (state_q == ACCESS) && !selReady &&
                      (toCnt_q == CntWidth'(TIMEOUT_CYC - 1));
`else
  assign timeoutHit = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      penable_q <= 1'b0;
      psel_q    <= '0;
      slot_q    <= '0;
      errPend_q <= 1'b0;
    end else begin
      errPend_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (transfer) begin
            paddr_q  <= addr;
            pwrite_q <= write;
            pwdata_q <= wdata;
            slot_q   <= addr[13:12];
            if (addrHit) begin
              state_q <= SETUP;
              psel_q  <= 4'b0001 << addr[13:12];
            end else begin
              errPend_q <= 1'b1;
            end
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          // A timeout reports its error one cycle later, after PSEL has dropped.
          if (selReady || timeoutHit) begin
            state_q   <= IDLE;
            psel_q    <= '0;
            penable_q <= 1'b0;
            errPend_q <= timeoutHit;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready = errPend_q | accessDone;
  assign err   = errPend_q;
  assign rdata = (accessDone && !pwrite_q) ? prdataSel : '0;

  assign apb.PADDR   = paddr_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PWDATA  = pwdata_q;
  assign apb.PENABLE = penable_q;
  assign apb.PSEL0   = psel_q[0];
  assign apb.PSEL1   = psel_q[1];
  assign apb.PSEL2   = psel_q[2];
  assign apb.PSEL3   = psel_q[3];

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: per-slot slave models with
// configurable wait states, expected transactions queued at issue time.
module tb_apb_master_bridge;

  localparam int TimeoutCyc = 16;
  localparam int Never      = 100000;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        transfer;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic [3:0]  pselVec;

  apb_master_bridge_if bus();

  apb_master_bridge #(
    .BASE_ADDR  (32'h1000_0000),
    .TIMEOUT_CYC(TimeoutCyc)
  ) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .transfer(transfer),
    .write   (write),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .ready   (ready),
    .err     (err),
    .apb     (bus)
  );

  always #5 PCLK = ~PCLK;

  assign pselVec = {bus.PSEL3, bus.PSEL2, bus.PSEL1, bus.PSEL0};

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic [31:0] rdata;
    logic        err;
    int          latency;
    logic [3:0]  pselMask;
    int          pselCycles;
    int          penCycles;
    int          startCycle;
  } txn_t;

  txn_t        sbQueue[$];
  int          assertCnt = 0;
  int          failCnt   = 0;
  int          cycleCnt  = 0;
  int          stallCfg[4];
  logic [31:0] prdataCfg[4];
  logic        strayEn;
  int          accCnt[4];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCnt++;
    if (observed !== expected) begin
      failCnt++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  always @(posedge PCLK) cycleCnt <= cycleCnt + 1;

  // Slave models: PREADY rises once a slot has spent more than stallCfg ACCESS cycles.
  always @(posedge PCLK) begin
    logic [3:0] rdyV;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (pselVec[i] && bus.PENABLE) accCnt[i]++;
      else accCnt[i] = 0;
      rdyV[i] = pselVec[i] && bus.PENABLE && (accCnt[i] > stallCfg[i]);
    end
    if (strayEn) rdyV[3] = ~bus.PREADY3;
    bus.PREADY0 = rdyV[0];
    bus.PREADY1 = rdyV[1];
    bus.PREADY2 = rdyV[2];
    bus.PREADY3 = rdyV[3];
    bus.PRDATA0 = prdataCfg[0];
    bus.PRDATA1 = prdataCfg[1];
    bus.PRDATA2 = prdataCfg[2];
    bus.PRDATA3 = strayEn ? $urandom : prdataCfg[3];
  end

  // Monitor: accumulates bus activity and scores each ready pulse against the queue head.
  always @(negedge PCLK) begin
    static int         pselCyc  = 0;
    static int         penCyc   = 0;
    static logic [3:0] maskAcc  = '0;
    static logic       unstable = 1'b0;
    txn_t exp;
    if (!PRESET) begin
      pselCyc  = 0;
      penCyc   = 0;
      maskAcc  = '0;
      unstable = 1'b0;
    end else begin
      if (pselVec != 4'b0000) begin
        pselCyc++;
        maskAcc |= pselVec;
        if (sbQueue.size() > 0 &&
            (bus.PADDR !== sbQueue[0].addr || bus.PWDATA !== sbQueue[0].wdata ||
             bus.PWRITE !== sbQueue[0].write))
          unstable = 1'b1;
      end
      if (bus.PENABLE) penCyc++;
      if (ready) begin
        if (sbQueue.size() == 0) begin
          checkOutput("spurious ready", 32'(ready), 32'd0);
        end else begin
          exp = sbQueue.pop_front();
          checkOutput("rdata", rdata, exp.rdata);
          checkOutput("err", 32'(err), 32'(exp.err));
          checkOutput("latency", 32'(cycleCnt - exp.startCycle + 1), 32'(exp.latency));
          checkOutput("psel mask", 32'(maskAcc), 32'(exp.pselMask));
          checkOutput("psel cycles", 32'(pselCyc), 32'(exp.pselCycles));
          checkOutput("penable cycles", 32'(penCyc), 32'(exp.penCycles));
          checkOutput("paddr", bus.PADDR, exp.addr);
          checkOutput("pwdata", bus.PWDATA, exp.wdata);
          checkOutput("bus stable", 32'(unstable), 32'd0);
          if (err) checkOutput("psel with err", 32'(pselVec), 32'd0);
        end
        pselCyc  = 0;
        penCyc   = 0;
        maskAcc  = '0;
        unstable = 1'b0;
      end
    end
  end

  function automatic txn_t modelTxn(input logic wr, input logic [31:0] a, input logic [31:0] wd);
    txn_t t;
    int   slot;
    slot         = int'(a[15:12]);
    t.addr       = a;
    t.wdata      = wd;
    t.write      = wr;
    t.startCycle = 0;
    if (a[31:16] == 16'h1000 && slot < 4) begin
      t.err        = 1'b0;
      t.rdata      = wr ? 32'd0 : prdataCfg[slot];
      t.latency    = 3 + stallCfg[slot];
      t.pselMask   = 4'b0001 << slot;
      t.pselCycles = 2 + stallCfg[slot];
      t.penCycles  = 1 + stallCfg[slot];
    end else begin
      t.err        = 1'b1;
      t.rdata      = 32'd0;
      t.latency    = 2;
      t.pselMask   = 4'b0000;
      t.pselCycles = 0;
      t.penCycles  = 0;
    end
    return t;
  endfunction

  task automatic applyTxn(input txn_t t, input bit track);
    @(negedge PCLK);
    transfer     = 1'b1;
    write        = t.write;
    addr         = t.addr;
    wdata        = t.wdata;
    t.startCycle = cycleCnt;
    if (track) sbQueue.push_back(t);
    @(negedge PCLK);
    transfer = 1'b0;
    write    = 1'($urandom);
    addr     = $urandom;
    wdata    = $urandom;
  endtask

  task automatic applyStimulus(input logic wr, input logic [31:0] a, input logic [31:0] wd);
    applyTxn(modelTxn(wr, a, wd), 1'b1);
  endtask

  task automatic waitDone(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge PCLK);
      if (sbQueue.size() == 0) return;
    end
    checkOutput("completion wait expired", 32'd1, 32'd0);
    sbQueue.delete();
  endtask

  initial begin
    txn_t        t;
    logic [3:0]  slotSel;
    logic [15:0] region;

    PRESET   = 1'b0;
    transfer = 1'b0;
    write    = 1'b0;
    addr     = '0;
    wdata    = '0;
    strayEn  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      stallCfg[i]  = 0;
      prdataCfg[i] = 32'hA0A0_0000 + 32'(i);
      accCnt[i]    = 0;
    end

    #12;
    checkOutput("reset ready", 32'(ready), 32'd0);
    checkOutput("reset err", 32'(err), 32'd0);
    checkOutput("reset rdata", rdata, 32'd0);
    checkOutput("reset psel", 32'(pselVec), 32'd0);
    checkOutput("reset penable", 32'(bus.PENABLE), 32'd0);
    checkOutput("reset pwrite", 32'(bus.PWRITE), 32'd0);
    checkOutput("reset paddr", bus.PADDR, 32'd0);
    checkOutput("reset pwdata", bus.PWDATA, 32'd0);
    @(negedge PCLK);
    PRESET = 1'b1;

    stallCfg[0] = 1;
    applyStimulus(1'b1, 32'h1000_0004, 32'h0000_04D2);
    waitDone(20);

    stallCfg[1]  = 0;
    prdataCfg[1] = 32'h3132_3334;
    applyStimulus(1'b0, 32'h1000_1014, 32'h0);
    waitDone(20);

    applyStimulus(1'b0, 32'h2000_0000, 32'h0);
    waitDone(20);
    applyStimulus(1'b0, 32'h1000_5000, 32'h0);
    waitDone(20);

    for (int n = 0; n < 12; n++) begin
      slotSel = 4'($urandom_range(0, 5));
      region  = ($urandom_range(0, 4) == 0) ? 16'h3000 : 16'h1000;
      if (slotSel < 4'd3) stallCfg[slotSel] = $urandom_range(0, 3);
      if (slotSel < 4'd4) prdataCfg[slotSel[1:0]] = $urandom;
      applyStimulus(1'($urandom_range(0, 1)), {region, slotSel, 10'($urandom), 2'b00}, $urandom);
      waitDone(20);
    end

    strayEn      = 1'b1;
    stallCfg[2]  = 10;
    prdataCfg[2] = 32'hC0FF_EE02;
    applyStimulus(1'b0, 32'h1000_2ABC, 32'h5A5A_1234);
    waitDone(40);
    strayEn = 1'b0;

    stallCfg[2] = Never;
    applyStimulus(1'b1, 32'h1000_2010, 32'hDEAD_BEEF);
    repeat (3) @(negedge PCLK);
    checkOutput("penable before reset", 32'(bus.PENABLE), 32'd1);
    #2 PRESET = 1'b0;
    #1;
    checkOutput("psel in reset", 32'(pselVec), 32'd0);
    checkOutput("penable in reset", 32'(bus.PENABLE), 32'd0);
    checkOutput("ready in reset", 32'(ready), 32'd0);
    checkOutput("paddr in reset", bus.PADDR, 32'd0);
    sbQueue.delete();
    @(negedge PCLK);
    @(negedge PCLK);
    PRESET      = 1'b1;
    stallCfg[2] = 0;
    applyStimulus(1'b0, 32'h1000_2020, 32'h0);
    waitDone(20);

    stallCfg[2] = Never;
    t = modelTxn(1'b0, 32'h1000_2008, 32'h0);
`ifdef APB_TIMEOUT_EN
    t.err        = 1'b1;
    t.rdata      = 32'd0;
    t.latency    = 3 + TimeoutCyc;
    t.pselCycles = 1 + TimeoutCyc;
    t.penCycles  = TimeoutCyc;
    applyTxn(t, 1'b1);
    waitDone(60);
`else
    applyTxn(t, 1'b0);
    repeat (100) @(negedge PCLK);
    checkOutput("access hold psel2", 32'(bus.PSEL2), 32'd1);
    checkOutput("access hold penable", 32'(bus.PENABLE), 32'd1);
    checkOutput("access hold ready", 32'(ready), 32'd0);
    #2 PRESET = 1'b0;
    @(negedge PCLK);
    PRESET = 1'b1;
`endif
    stallCfg[2] = 0;
    repeat (2) @(negedge PCLK);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule
